// File: rtl/breakpoint_unit.sv
// Multi-channel instruction-fetch breakpoint unit with off/always/count/one-shot modes.
// Optional macro BREAKPOINT_INIT_LOAD_EN preloads channel 0 from i_initAddress during INIT.
module breakpoint_unit #(
  parameter int ADDR_WIDTH  = 16,
  parameter int NUM_BP      = 4,
  parameter int COUNT_WIDTH = 8,
  localparam int IDX_W      = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                   i_oszClk,
  input  logic                   i_resetn,
  input  logic                   i_enable,
  input  logic                   i_wrEn,
  input  logic [IDX_W-1:0]       i_wrIndex,
  input  logic [ADDR_WIDTH-1:0]  i_wrAddress,
  input  logic [1:0]             i_wrMode,
  input  logic [COUNT_WIDTH-1:0] i_wrCount,
  input  logic [ADDR_WIDTH-1:0]  i_initAddress,
  input  logic                   i_fetchValid,
  input  logic [ADDR_WIDTH-1:0]  i_fetchAddress,
  input  logic                   i_resume,
  output logic                   o_haltReq,
  output logic                   o_hitValid,
  output logic [IDX_W-1:0]       o_hitIndex,
  output logic [NUM_BP-1:0]      o_armed
);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_HALTED,
    S_SKIP
  } state_e;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_ALWAYS = 2'b01;
  localparam logic [1:0] MODE_COUNT  = 2'b10;
  localparam logic [1:0] MODE_ONCE   = 2'b11;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q  [NUM_BP];
  logic [ADDR_WIDTH-1:0]  addr_d  [NUM_BP];
  logic [1:0]             mode_q  [NUM_BP];
  logic [1:0]             mode_d  [NUM_BP];
  logic [COUNT_WIDTH-1:0] k_q     [NUM_BP];
  logic [COUNT_WIDTH-1:0] k_d     [NUM_BP];
  logic [COUNT_WIDTH-1:0] cnt_q   [NUM_BP];
  logic [COUNT_WIDTH-1:0] cnt_d   [NUM_BP];
  logic [IDX_W-1:0]       hitIndex_q, hitIndex_d;
  logic                   hitValid_q, hitValid_d;
  logic [NUM_BP-1:0]      hit;
  logic [NUM_BP-1:0]      wrSel;
  logic [NUM_BP-1:0]      match;

`ifndef BREAKPOINT_INIT_LOAD_EN
  logic unused_initAddress;
  assign unused_initAddress = ^i_initAddress;
`endif

  always_comb begin
    for (int i = 0; i < NUM_BP; i++) begin
      wrSel[i] = i_wrEn && (state_q != S_INIT) && (i_wrIndex == IDX_W'(i));
      match[i] = i_enable && i_fetchValid && (mode_q[i] != MODE_OFF) &&
                 (addr_q[i] == i_fetchAddress);
    end
  end

  always_comb begin
    state_d    = state_q;
    hitIndex_d = hitIndex_q;
    hitValid_d = 1'b0;
    hit        = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      addr_d[i] = addr_q[i];
      mode_d[i] = mode_q[i];
      k_d[i]    = k_q[i];
      cnt_d[i]  = cnt_q[i];
    end

    case (state_q)
      S_INIT: begin
        state_d = S_RUN;
`ifdef BREAKPOINT_INIT_LOAD_EN
        addr_d[0] = i_initAddress;
        mode_d[0] = MODE_ALWAYS;
        k_d[0]    = '0;
        cnt_d[0]  = '0;
`endif
      end
      S_RUN: begin
        // A channel being rewritten this cycle is excluded from evaluation.
        for (int i = 0; i < NUM_BP; i++) begin
          if (match[i] && !wrSel[i]) begin
            case (mode_q[i])
              MODE_ALWAYS: hit[i] = 1'b1;
              MODE_COUNT: begin
                if (cnt_q[i] > COUNT_WIDTH'(1)) begin
                  cnt_d[i] = cnt_q[i] - COUNT_WIDTH'(1);
                end else begin
                  hit[i]   = 1'b1;
                  cnt_d[i] = k_q[i];
                end
              end
              MODE_ONCE: begin
                hit[i]    = 1'b1;
                mode_d[i] = MODE_OFF;
              end
              default: ;
            endcase
          end
        end
        if (|hit) begin
          state_d    = S_HALTED;
          hitValid_d = 1'b1;
          for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (hit[i]) hitIndex_d = IDX_W'(i);
          end
        end
      end
      S_HALTED: begin
        if (i_resume) state_d = S_RUN == S_RUN ? S_SKIP : S_SKIP;
      end
      S_SKIP: begin
        if (!i_enable || i_fetchValid) state_d = S_RUN;
      end
      default: state_d = S_INIT;
    endcase

    for (int i = 0; i < NUM_BP; i++) begin
      if (wrSel[i]) begin
        addr_d[i] = i_wrAddress;
        mode_d[i] = i_wrMode;
        k_d[i]    = i_wrCount;
        cnt_d[i]  = i_wrCount;
      end
    end
  end

  always_ff @(posedge i_oszClk) begin
    if (!i_resetn) begin
      state_q    <= S_INIT;
      hitIndex_q <= '0;
      hitValid_q <= 1'b0;
      for (int i = 0; i < NUM_BP; i++) begin
        addr_q[i] <= '0;
        mode_q[i] <= MODE_OFF;
        k_q[i]    <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      hitIndex_q <= hitIndex_d;
      hitValid_q <= hitValid_d;
      for (int i = 0; i < NUM_BP; i++) begin
        addr_q[i] <= addr_d[i];
        mode_q[i] <= mode_d[i];
        k_q[i]    <= k_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BP; i++) begin
      o_armed[i] = (mode_q[i] != MODE_OFF);
    end
  end

  assign o_haltReq  = (state_q == S_HALTED);
  assign o_hitValid = hitValid_q;
  assign o_hitIndex = hitIndex_q;

endmodule

// File: tb/tb_breakpoint_unit.sv
// Directed self-checking bench for breakpoint_unit (default build; macro branch optional).
module tb_breakpoint_unit;

  localparam int AW = 16;
  localparam int NB = 4;
  localparam int CW = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic          enable;
  logic          wrEn;
  logic [IW-1:0] wrIndex;
  logic [AW-1:0] wrAddress;
  logic [1:0]    wrMode;
  logic [CW-1:0] wrCount;
  logic [AW-1:0] initAddress;
  logic          fetchValid;
  logic [AW-1:0] fetchAddress;
  logic          resume;
  logic          haltReq;
  logic          hitValid;
  logic [IW-1:0] hitIndex;
  logic [NB-1:0] armed;

  int totalChecks = 0;
  int badChecks   = 0;

  breakpoint_unit #(.ADDR_WIDTH(AW), .NUM_BP(NB), .COUNT_WIDTH(CW)) dut (
    .i_oszClk      (clk),
    .i_resetn      (resetn),
    .i_enable      (enable),
    .i_wrEn        (wrEn),
    .i_wrIndex     (wrIndex),
    .i_wrAddress   (wrAddress),
    .i_wrMode      (wrMode),
    .i_wrCount     (wrCount),
    .i_initAddress (initAddress),
    .i_fetchValid  (fetchValid),
    .i_fetchAddress(fetchAddress),
    .i_resume      (resume),
    .o_haltReq     (haltReq),
    .o_hitValid    (hitValid),
    .o_hitIndex    (hitIndex),
    .o_armed       (armed)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus, sampled 1 time unit after the edge, then idle inputs.
  task automatic applyStimulus(input logic we, input logic [IW-1:0] wi,
                               input logic [AW-1:0] wa, input logic [1:0] wm,
                               input logic [CW-1:0] wc, input logic fv,
                               input logic [AW-1:0] fa, input logic rs);
    wrEn = we; wrIndex = wi; wrAddress = wa; wrMode = wm; wrCount = wc;
    fetchValid = fv; fetchAddress = fa; resume = rs;
    @(posedge clk);
    #1;
    wrEn = 1'b0; fetchValid = 1'b0; resume = 1'b0;
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    applyStimulus(1'b0, '0, '0, 2'b00, '0, 1'b1, a, 1'b0);
  endtask

  task automatic writeBp(input logic [IW-1:0] i, input logic [AW-1:0] a,
                         input logic [1:0] m, input logic [CW-1:0] k);
    applyStimulus(1'b1, i, a, m, k, 1'b0, '0, 1'b0);
  endtask

  task automatic doResume();
    applyStimulus(1'b0, '0, '0, 2'b00, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 2'b00, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b1; initAddress = 16'h00AB;
    wrEn = 1'b0; wrIndex = '0; wrAddress = '0; wrMode = 2'b00; wrCount = '0;
    fetchValid = 1'b0; fetchAddress = '0; resume = 1'b0;
    idle();
    idle();
    checkOutput("rst_halt", 32'(haltReq), 32'd0);
    checkOutput("rst_valid", 32'(hitValid), 32'd0);
    checkOutput("rst_index", 32'(hitIndex), 32'd0);
    checkOutput("rst_armed", 32'(armed), 32'd0);

    resetn = 1'b1;
    idle();
`ifdef BREAKPOINT_INIT_LOAD_EN
    checkOutput("init_armed", 32'(armed), 32'b0001);
    fetch(16'h00AB);
    checkOutput("init_halt", 32'(haltReq), 32'd1);
    checkOutput("init_index", 32'(hitIndex), 32'd0);
    doResume();
    fetch(16'h0000);
    writeBp(2'd0, 16'h0000, 2'b00, 8'd0);
`else
    checkOutput("init_armed", 32'(armed), 32'b0000);
    fetch(16'h00AB);
    checkOutput("init_nohalt", 32'(haltReq), 32'd0);
`endif

    // Always-mode hit on channel 1, pulse timing and halt hold
    writeBp(2'd1, 16'h0040, 2'b01, 8'd0);
    checkOutput("t1_armed", 32'(armed), 32'b0010);
    fetch(16'h0040);
    checkOutput("t1_halt", 32'(haltReq), 32'd1);
    checkOutput("t1_valid", 32'(hitValid), 32'd1);
    checkOutput("t1_index", 32'(hitIndex), 32'd1);
    idle();
    checkOutput("t1_valid_low", 32'(hitValid), 32'd0);
    checkOutput("t1_hold", 32'(haltReq), 32'd1);
    enable = 1'b0;
    fetch(16'h0040);
    enable = 1'b1;
    checkOutput("t1_still_halted", 32'(haltReq), 32'd1);
    doResume();
    checkOutput("t1_resume", 32'(haltReq), 32'd0);
    fetch(16'h0040);
    checkOutput("t1_skip", 32'(haltReq), 32'd0);
    writeBp(2'd1, 16'h0000, 2'b00, 8'd0);

    // Count mode K=3: third match halts, counter reloads to 3
    writeBp(2'd0, 16'h0010, 2'b10, 8'd3);
    fetch(16'h0010);
    checkOutput("t2_f1", 32'(haltReq), 32'd0);
    fetch(16'h0010);
    checkOutput("t2_f2", 32'(haltReq), 32'd0);
    fetch(16'h0010);
    checkOutput("t2_f3", 32'(haltReq), 32'd1);
    checkOutput("t2_index", 32'(hitIndex), 32'd0);
    doResume();
    fetch(16'h0010);
    fetch(16'h0010);
    checkOutput("t2_r1", 32'(haltReq), 32'd0);
    fetch(16'h0010);
    checkOutput("t2_r2", 32'(haltReq), 32'd0);
    fetch(16'h0010);
    checkOutput("t2_r3", 32'(haltReq), 32'd1);
    doResume();
    fetch(16'h0000);
    writeBp(2'd0, 16'h0010, 2'b10, 8'd0);
    fetch(16'h0010);
    checkOutput("t2_k0", 32'(haltReq), 32'd1);
    doResume();
    fetch(16'h0000);
    writeBp(2'd0, 16'h0000, 2'b00, 8'd0);

    // One-shot on channel 2 disarms itself
    writeBp(2'd2, 16'h0020, 2'b11, 8'd0);
    checkOutput("t3_armed", 32'(armed), 32'b0100);
    fetch(16'h0020);
    checkOutput("t3_halt", 32'(haltReq), 32'd1);
    checkOutput("t3_index", 32'(hitIndex), 32'd2);
    checkOutput("t3_disarm", 32'(armed), 32'b0000);
    doResume();
    fetch(16'h0020);
    fetch(16'h0020);
    checkOutput("t3_nohalt", 32'(haltReq), 32'd0);

    // Priority: lowest index reports; skip consumes only one fetch
    writeBp(2'd0, 16'h0080, 2'b01, 8'd0);
    writeBp(2'd3, 16'h0080, 2'b01, 8'd0);
    checkOutput("t4_armed", 32'(armed), 32'b1001);
    fetch(16'h0080);
    checkOutput("t4_index", 32'(hitIndex), 32'd0);
    doResume();
    fetch(16'h0080);
    checkOutput("t4_skip", 32'(haltReq), 32'd0);
    fetch(16'h0080);
    checkOutput("t4_rehalt", 32'(haltReq), 32'd1);
    doResume();
    fetch(16'h0000);
    writeBp(2'd0, 16'h0000, 2'b00, 8'd0);
    fetch(16'h0080);
    checkOutput("t4_index3", 32'(hitIndex), 32'd3);
    doResume();
    fetch(16'h0000);

    // Write wins on its own channel; other channels still evaluated
    applyStimulus(1'b1, 2'd3, 16'h0090, 2'b01, 8'd0, 1'b1, 16'h0080, 1'b0);
    checkOutput("t5_wrwins", 32'(haltReq), 32'd0);
    fetch(16'h0090);
    checkOutput("t5_newaddr", 32'(haltReq), 32'd1);
    doResume();
    fetch(16'h0000);
    applyStimulus(1'b1, 2'd1, 16'h0050, 2'b01, 8'd0, 1'b1, 16'h0090, 1'b0);
    checkOutput("t5_other_halt", 32'(haltReq), 32'd1);
    checkOutput("t5_other_index", 32'(hitIndex), 32'd3);
    checkOutput("t5_armed", 32'(armed), 32'b1010);
    doResume();
    fetch(16'h0000);

    // Global enable off: no hits
    enable = 1'b0;
    fetch(16'h0090);
    checkOutput("t6_disabled", 32'(haltReq), 32'd0);
    enable = 1'b1;

    // Reset while halted clears everything
    fetch(16'h0050);
    checkOutput("t7_halt", 32'(haltReq), 32'd1);
    checkOutput("t7_index", 32'(hitIndex), 32'd1);
    resetn = 1'b0;
    fetch(16'h0050);
    checkOutput("t7_rst_halt", 32'(haltReq), 32'd0);
    checkOutput("t7_rst_armed", 32'(armed), 32'd0);
    checkOutput("t7_rst_index", 32'(hitIndex), 32'd0);
    checkOutput("t7_rst_valid", 32'(hitValid), 32'd0);
    resetn = 1'b1;
    idle();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
